// File: rtl/bure_ctrl_pkg.sv
// bure_ctrl_pkg: shared types and sizing helpers for the decode-stage hazard controller.
package bure_ctrl_pkg;
  typedef enum logic {RUN, FLUSH} bure_hz_state_e;
  localparam int REG_ADDR_W = 5;
  function automatic int flush_cnt_w(input int flush_cycles);
    return $clog2(flush_cycles + 1);
  endfunction
endpackage

// File: rtl/bure_scoreboard.sv
// bure_scoreboard: per-register pending bitmap with write-first clear view; set beats clear, x0 never set.
module bure_scoreboard
  import bure_ctrl_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  output logic [NREGS-1:0]      sb,
  output logic [NREGS-1:0]      sb_eff
);
  logic [NREGS-1:0] clr_mask, set_mask;
  always_comb begin
    clr_mask = clr_en ? NREGS'(1) << clr_addr : '0;
    set_mask = (set_en && set_addr != '0) ? NREGS'(1) << set_addr : '0;
    sb_eff   = sb & ~clr_mask;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sb <= '0;
    else        sb <= (sb_eff | set_mask) & ~NREGS'(1);
endmodule

// File: rtl/bure_hazard_ctrl.sv
// bure_hazard_ctrl: decode-stage sequencer; stalls IF/ID on load-use hazards and flushes ID after redirects.
module bure_hazard_ctrl
  import bure_ctrl_pkg::*;
#(
  parameter int NREGS        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_id_valid,
  input  logic                  i_id_rs1_used,
  input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
  input  logic                  i_id_is_load_op,
  input  logic                  i_id_rd_wen,
  input  logic [REG_ADDR_W-1:0] i_id_rd_addr,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
  input  logic                  i_redirect_valid,
  output logic                  o_if_stall,
  output logic                  o_id_stall,
  output logic                  o_id_flush,
  output logic                  o_ex_bubble,
  output logic [NREGS-1:0]      o_scoreboard,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt
);
  localparam int FCW = flush_cnt_w(FLUSH_CYCLES);
  localparam logic [FCW-1:0] RELOAD = FCW'(FLUSH_CYCLES - 1);
  bure_hz_state_e state, state_nx;
  logic [FCW-1:0] cnt, cnt_nx;
  logic [NREGS-1:0] sb, sb_eff;
  logic haz, flush, stall, iss;
  bure_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk      (i_clk),
    .rst_n    (i_rstn),
    .clr_en   (i_wb_valid),
    .clr_addr (i_wb_rd_addr),
    .set_en   (iss & i_id_is_load_op & i_id_rd_wen),
    .set_addr (i_id_rd_addr),
    .sb       (sb),
    .sb_eff   (sb_eff)
  );
  // cnt holds the flush cycles still owed after the current one
  always_comb begin
    haz      = i_id_valid & ((i_id_rs1_used & sb_eff[i_id_rs1_addr]) |
                             (i_id_rs2_used & sb_eff[i_id_rs2_addr]));
    flush    = i_redirect_valid | (state == FLUSH);
    stall    = haz & ~flush;
    iss      = i_id_valid & ~haz & ~flush;
    cnt_nx   = i_redirect_valid ? RELOAD : (state == FLUSH) ? cnt - FCW'(1) : cnt;
    state_nx = (flush && cnt_nx != '0) ? FLUSH : RUN;
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      state       <= RUN;
      cnt         <= '0;
      o_stall_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (stall && ~&o_stall_cnt) o_stall_cnt <= o_stall_cnt + CNT_WIDTH'(1);
    end
  assign o_if_stall   = stall;
  assign o_id_stall   = stall;
  assign o_ex_bubble  = stall;
  assign o_id_flush   = flush;
  assign o_scoreboard = sb;
endmodule

// File: tb/tb_bure_hazard_ctrl.sv
// tb_bure_hazard_ctrl: directed and random stimulus against a queue-based reference model with a decoupled monitor.
module tb_bure_hazard_ctrl;
  localparam int NREGS = 32;
  localparam int FC    = 2;
  localparam int CW    = 32;
  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, rs1_used, rs2_used, is_load, rd_wen, wb_valid, redirect;
  logic [4:0] rs1, rs2, rd, wb_rd;
  logic if_stall, id_stall, id_flush, ex_bubble;
  logic [NREGS-1:0] sb_out;
  logic [CW-1:0] stall_cnt;
  always #5 clk = ~clk;
  bure_hazard_ctrl #(.NREGS(NREGS), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rstn(rst_n),
    .i_id_valid(id_valid), .i_id_rs1_used(rs1_used), .i_id_rs1_addr(rs1),
    .i_id_rs2_used(rs2_used), .i_id_rs2_addr(rs2), .i_id_is_load_op(is_load),
    .i_id_rd_wen(rd_wen), .i_id_rd_addr(rd), .i_wb_valid(wb_valid), .i_wb_rd_addr(wb_rd),
    .i_redirect_valid(redirect),
    .o_if_stall(if_stall), .o_id_stall(id_stall), .o_id_flush(id_flush),
    .o_ex_bubble(ex_bubble), .o_scoreboard(sb_out), .o_stall_cnt(stall_cnt)
  );
  typedef struct {
    logic stall;
    logic flush;
    logic [NREGS-1:0] sb;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t q[$];
  int n_checks = 0, n_fail = 0;
  bit pend[NREGS];
  int flush_left;
  longint unsigned scnt;
  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic void model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    flush_left = 0;
    scnt = 0;
  endfunction
  task automatic idle();
    id_valid = 0; rs1_used = 0; rs2_used = 0; is_load = 0; rd_wen = 0;
    wb_valid = 0; redirect = 0; rs1 = 0; rs2 = 0; rd = 0; wb_rd = 0;
  endtask
  task automatic load(input int r);
    idle(); id_valid = 1; is_load = 1; rd_wen = 1; rd = 5'(r);
  endtask
  task automatic use1(input int r);
    idle(); id_valid = 1; rs1_used = 1; rs1 = 5'(r);
  endtask
  // Model one cycle from the current inputs, queue the expectation, advance to the next cycle.
  task automatic tick();
    exp_t e;
    bit eff[NREGS];
    bit haz, fl, st, issue;
    if (!rst_n) model_reset();
    eff = pend;
    if (wb_valid) eff[wb_rd] = 1'b0;
    haz   = id_valid && ((rs1_used && eff[rs1]) || (rs2_used && eff[rs2]));
    fl    = redirect || flush_left > 0;
    st    = haz && !fl;
    issue = id_valid && !haz && !fl;
    e.sb = '0;
    foreach (pend[i]) e.sb[i] = pend[i];
    e.stall = st;
    e.flush = fl;
    e.cnt   = CW'(scnt);
    q.push_back(e);
    if (rst_n) begin
      pend = eff;
      if (issue && is_load && rd_wen && rd != 0) pend[rd] = 1'b1;
      if (redirect) flush_left = FC - 1;
      else if (flush_left > 0) flush_left--;
      if (st && scnt != 64'hFFFF_FFFF) scnt++;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("if_stall", 64'(if_stall), 64'(e.stall));
        check("id_stall", 64'(id_stall), 64'(e.stall));
        check("ex_bubble", 64'(ex_bubble), 64'(e.stall));
        check("id_flush", 64'(id_flush), 64'(e.flush));
        check("scoreboard", 64'(sb_out), 64'(e.sb));
        check("stall_cnt", 64'(stall_cnt), 64'(e.cnt));
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 0;
    idle();
    model_reset();
    @(posedge clk); #1;
    tick(); tick();
    rst_n = 1;
    tick();
    load(5); tick();
    use1(5); tick(); tick();
    use1(5); wb_valid = 1; wb_rd = 5; tick();
    idle(); tick();
    load(0); tick();
    idle(); id_valid = 1; rs1_used = 1; rs2_used = 1; tick();
    idle(); redirect = 1; tick();
    load(9); tick();
    idle(); tick(); tick();
    load(6); tick();
    use1(6); tick();
    use1(6); redirect = 1; tick();
    idle(); wb_valid = 1; wb_rd = 6; tick();
    load(7); tick();
    load(7); wb_valid = 1; wb_rd = 7; tick();
    idle(); tick();
    wb_valid = 1; wb_rd = 7; tick();
    load(5); tick();
    load(8); tick();
    idle(); redirect = 1; tick();
    idle(); rst_n = 0; tick();
    tick();
    rst_n = 1; tick(); tick();
    for (int i = 0; i < 1500; i++) begin
      id_valid = ($urandom_range(0, 9) < 7);
      rs1_used = $urandom_range(0, 1);
      rs2_used = $urandom_range(0, 1);
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      is_load  = ($urandom_range(0, 9) < 4);
      rd_wen   = ($urandom_range(0, 9) < 8);
      rd       = 5'($urandom_range(0, 7));
      wb_valid = ($urandom_range(0, 9) < 3);
      wb_rd    = 5'($urandom_range(0, 7));
      redirect = ($urandom_range(0, 99) < 6);
      tick();
    end
    idle(); tick();
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
